// File: rtl/bolme_birimi.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) for the YURUT stage.
// Restoring division, one quotient bit per cycle, with a done/stall handshake.
module bolme_birimi #(
    parameter int unsigned VERI_BIT = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                istek_i,
    input  logic [1:0]          islem_i,
    input  logic [VERI_BIT-1:0] bolunen_i,
    input  logic [VERI_BIT-1:0] bolen_i,
    input  logic                durdur_i,
    output logic [VERI_BIT-1:0] sonuc_o,
    output logic                bitti_o,
    output logic                mesgul_o
);

    localparam int unsigned SayacBit = $clog2(VERI_BIT);
    localparam logic [VERI_BIT-1:0] EnKucuk = {1'b1, {(VERI_BIT-1){1'b0}}};

    typedef enum logic [1:0] {StBosta, StCalis, StBitti} durum_e;

    durum_e              durum_q, durum_d;
    logic [VERI_BIT-1:0] sonuc_q, sonuc_d;
    logic [VERI_BIT-1:0] bolum_q, bolum_d;
    logic [VERI_BIT-1:0] bolen_q, bolen_d;
    logic [VERI_BIT:0]   kalan_q, kalan_d;
    logic [SayacBit-1:0] sayac_q, sayac_d;
    logic                kalan_sec_q, kalan_sec_d;
    logic                bolum_isaret_q, bolum_isaret_d;
    logic                kalan_isaret_q, kalan_isaret_d;

    logic                isaretli, a_negatif, b_negatif, sifira_bolme, tasma;
    logic [VERI_BIT-1:0] a_mutlak, b_mutlak;
    logic [VERI_BIT:0]   kalan_kay, fark, kalan_adim;
    logic [VERI_BIT-1:0] bolum_adim, bolum_son, kalan_son;
    logic                bolum_bit;

    always_comb begin
        isaretli     = ~islem_i[0];
        a_negatif    = isaretli & bolunen_i[VERI_BIT-1];
        b_negatif    = isaretli & bolen_i[VERI_BIT-1];
        a_mutlak     = a_negatif ? (~bolunen_i + 1'b1) : bolunen_i;
        b_mutlak     = b_negatif ? (~bolen_i + 1'b1) : bolen_i;
        sifira_bolme = (bolen_i == '0);
        tasma        = isaretli & (bolunen_i == EnKucuk) & (bolen_i == '1);

        // Remainder is 33 bits wide so the shifted value never loses its carry.
        kalan_kay  = {kalan_q[VERI_BIT-1:0], bolum_q[VERI_BIT-1]};
        fark       = kalan_kay - {1'b0, bolen_q};
        bolum_bit  = ~fark[VERI_BIT];
        kalan_adim = bolum_bit ? fark : kalan_kay;
        bolum_adim = {bolum_q[VERI_BIT-2:0], bolum_bit};
        bolum_son  = bolum_isaret_q ? (~bolum_adim + 1'b1) : bolum_adim;
        kalan_son  = kalan_isaret_q ? (~kalan_adim[VERI_BIT-1:0] + 1'b1)
                                    : kalan_adim[VERI_BIT-1:0];
    end

    always_comb begin
        durum_d        = durum_q;
        sonuc_d        = sonuc_q;
        bolum_d        = bolum_q;
        bolen_d        = bolen_q;
        kalan_d        = kalan_q;
        sayac_d        = sayac_q;
        kalan_sec_d    = kalan_sec_q;
        bolum_isaret_d = bolum_isaret_q;
        kalan_isaret_d = kalan_isaret_q;
        bitti_o        = 1'b1;

        unique case (durum_q)
            StBosta: begin
                // Combinational so the control unit stalls in the arrival cycle.
                bitti_o = ~istek_i;
                if (istek_i) begin
                    kalan_sec_d    = islem_i[1];
                    bolum_isaret_d = a_negatif ^ b_negatif;
                    kalan_isaret_d = a_negatif;
                    bolum_d        = a_mutlak;
                    bolen_d        = b_mutlak;
                    kalan_d        = '0;
                    if (sifira_bolme) begin
                        sonuc_d = islem_i[1] ? bolunen_i : '1;
                        durum_d = StBitti;
                    end else if (tasma) begin
                        sonuc_d = islem_i[1] ? '0 : EnKucuk;
                        durum_d = StBitti;
                    end else begin
                        sayac_d = SayacBit'(VERI_BIT - 1);
                        durum_d = StCalis;
                    end
                end
            end
            StCalis: begin
                bitti_o = 1'b0;
                bolum_d = bolum_adim;
                kalan_d = kalan_adim;
                sayac_d = sayac_q - 1'b1;
                if (sayac_q == '0) begin
                    sonuc_d = kalan_sec_q ? kalan_son : bolum_son;
                    durum_d = StBitti;
                end
            end
            StBitti: begin
                bitti_o = 1'b1;
                if (!durdur_i) begin
                    durum_d = StBosta;
                end
            end
            default: begin
                durum_d = StBosta;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q        <= StBosta;
            sonuc_q        <= '0;
            bolum_q        <= '0;
            bolen_q        <= '0;
            kalan_q        <= '0;
            sayac_q        <= '0;
            kalan_sec_q    <= 1'b0;
            bolum_isaret_q <= 1'b0;
            kalan_isaret_q <= 1'b0;
        end else begin
            durum_q        <= durum_d;
            sonuc_q        <= sonuc_d;
            bolum_q        <= bolum_d;
            bolen_q        <= bolen_d;
            kalan_q        <= kalan_d;
            sayac_q        <= sayac_d;
            kalan_sec_q    <= kalan_sec_d;
            bolum_isaret_q <= bolum_isaret_d;
            kalan_isaret_q <= kalan_isaret_d;
        end
    end

    assign sonuc_o  = sonuc_q;
    assign mesgul_o = (durum_q != StBosta);

endmodule

// File: tb/tb_bolme_birimi.sv
// Self-checking bench for bolme_birimi: directed table, handshake corner cases,
// and random operations against an arithmetic reference model.
module tb_bolme_birimi;

    logic        clk = 1'b0;
    logic        rst, istek, durdur;
    logic [1:0]  islem;
    logic [31:0] bolunen, bolen, sonuc;
    logic        bitti, mesgul;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bolme_birimi #(.VERI_BIT(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .istek_i   (istek),
        .islem_i   (islem),
        .bolunen_i (bolunen),
        .bolen_i   (bolen),
        .durdur_i  (durdur),
        .sonuc_o   (sonuc),
        .bitti_o   (bitti),
        .mesgul_o  (mesgul)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vek_t;

    vek_t tablo[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit arithmetic; the overflow case falls out of truncation.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        sa = op[0] ? longint'(a) : longint'($signed(a));
        sb = op[0] ? longint'(b) : longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    // Starts an operation in the next cycle, waits for done, checks latency and result.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        int n;
        int lat;
        lat = (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
        @(posedge clk); #1;
        istek = 1'b1; islem = op; bolunen = a; bolen = b;
        #1;
        chk({name, "_bitti_c0"}, 32'(bitti), 32'd0);
        n = 0;
        while (bitti !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(lat));
        chk({name, "_sonuc"}, sonuc, exp);
        chk({name, "_mesgul"}, 32'(mesgul), 32'd1);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [31:0] ozel[5];

        tablo[0]  = '{2'b01, 32'd100,        32'd7,          32'h0000_000E, "divu_100_7"};
        tablo[1]  = '{2'b11, 32'd100,        32'd7,          32'h0000_0002, "remu_100_7"};
        tablo[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, "div_m7_2"};
        tablo[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, "rem_m7_2"};
        tablo[4]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, "div_7_m2"};
        tablo[5]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF, "divu_5_0"};
        tablo[6]  = '{2'b10, 32'd5,          32'd0,          32'h0000_0005, "rem_5_0"};
        tablo[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, "div_ovf"};
        tablo[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, "rem_ovf"};
        tablo[9]  = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, "divu_nonovf"};
        tablo[10] = '{2'b10, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF, "rem_m7_m2"};
        tablo[11] = '{2'b00, 32'd0,          32'd1,          32'h0000_0000, "div_0_1"};

        rst = 1'b1; istek = 1'b0; durdur = 1'b0; islem = 2'b00; bolunen = '0; bolen = '0;
        @(posedge clk); #1;
        chk("reset_sonuc", sonuc, 32'h0);
        chk("reset_mesgul", 32'(mesgul), 32'd0);
        chk("reset_bitti", 32'(bitti), 32'd1);

        // Reset wins over a simultaneous request.
        istek = 1'b1; bolunen = 32'd9; bolen = 32'd2;
        @(posedge clk); #1;
        chk("reset_dominates", 32'(mesgul), 32'd0);
        istek = 1'b0; rst = 1'b0;

        foreach (tablo[i]) run_op(tablo[i].op, tablo[i].a, tablo[i].b, tablo[i].exp,
                                  tablo[i].name);

        // Hold in BITTI for cycles 33..35 via durdur.
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, "divu_max_1");
        durdur = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("hold_bitti", 32'(bitti), 32'd1);
            chk("hold_sonuc", sonuc, 32'hFFFF_FFFF);
            chk("hold_mesgul", 32'(mesgul), 32'd1);
        end
        durdur = 1'b0; istek = 1'b0;
        @(posedge clk); #1;
        chk("release_mesgul", 32'(mesgul), 32'd0);
        chk("release_bitti", 32'(bitti), 32'd1);
        run_op(2'b01, 32'd1000, 32'd7, 32'h0000_008E, "divu_1000_7");

        // Abort mid-operation with reset in cycle 10.
        @(posedge clk); #1;
        istek = 1'b1; islem = 2'b01; bolunen = 32'd1000; bolen = 32'd3;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("abort_busy", 32'(mesgul), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; istek = 1'b0;
        #1;
        chk("abort_mesgul", 32'(mesgul), 32'd0);
        chk("abort_sonuc", sonuc, 32'h0);
        chk("abort_bitti", 32'(bitti), 32'd1);
        run_op(2'b01, 32'd1000, 32'd3, 32'h0000_014D, "divu_1000_3");

        ozel[0] = 32'h0; ozel[1] = 32'h1; ozel[2] = 32'hFFFF_FFFF;
        ozel[3] = 32'h8000_0000; ozel[4] = 32'h7FFF_FFFF;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? ozel[$urandom_range(0, 4)] : $urandom;
            case ($urandom_range(0, 4))
                0:       b = ozel[$urandom_range(0, 4)];
                1:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op(op, a, b, model(op, a, b), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
